// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_ctrl_if
//  Description : Request/response bus between the CPU memory stage and the
//                data-RAM access controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Requester side (CPU memory stage)
    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_ctrl
//  Description : Byte/half/word load-store controller for a word-addressed
//                RAM with synchronous write and combinational read.
//                Sub-word stores are performed as read-modify-write.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ram_access_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [31:0]            ram_d,
    output logic                   ram_we,
    input  wire logic [31:0]       ram_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_we;
    logic [ADDR_W-1:0]   r_word;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rbuf;
    logic                r_err;
    logic [31:0]         r_rdata;

    logic                w_req_err;
    logic [31:0]         w_ram_d;
    logic [31:0]         w_load_ext;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    // Upper address bits alias onto the RAM and are deliberately dropped.
    logic                w_unused_addr;
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

    // Illegal size, or a half/word access that is not naturally aligned.
    assign w_req_err = (bus.req_size == 2'b11) ||
                       ((bus.req_size == c_SIZE_HALF) && bus.req_addr[0]) ||
                       ((bus.req_size == c_SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));

    // State register and latched request / response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_word     <= '0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_word     <= bus.req_addr[ADDR_W+1:2];
                        r_lane     <= bus.req_addr[1:0];
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata;
                        r_err      <= w_req_err;
                        if (w_req_err) begin
                            r_rdata <= '0;
                        end
                    end
                end
                S_READ: begin
                    r_rbuf <= ram_q;
                    if (!r_we) begin
                        r_rdata <= w_load_ext;
                    end
                end
                S_WRITE: begin
                    r_rdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_err) begin
                        w_state_next = S_RESP;
                    end else if (bus.req_we && (bus.req_size == c_SIZE_WORD)) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ:  w_state_next = r_we ? S_WRITE : S_RESP;
            S_WRITE: w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for stores (little-endian).
    always_comb begin
        w_byte     = ram_q[{r_lane, 3'b000} +: 8];
        w_half     = ram_q[{r_lane[1], 4'b0000} +: 16];
        w_load_ext = ram_q;
        case (r_size)
            c_SIZE_BYTE: w_load_ext = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            c_SIZE_HALF: w_load_ext = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default:     w_load_ext = ram_q;
        endcase

        w_ram_d = '0;
        if (r_state == S_WRITE) begin
            w_ram_d = r_rbuf;
            case (r_size)
                c_SIZE_BYTE: w_ram_d[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
                c_SIZE_HALF: w_ram_d[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
                default:     w_ram_d = r_wdata;
            endcase
        end
    end

    // A reset landing in the WRITE cycle must not commit the write.
    assign ram_we         = (r_state == S_WRITE) & ~rst;
    assign ram_d          = w_ram_d;
    assign ram_addr       = r_word;

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_err   = (r_state == S_RESP) & r_err;
    assign bus.resp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator-side controller for the 1024×32 data RAM, which has a synchronous write and a combinational read. It accepts byte, halfword and word load/store requests from the CPU memory stage through a valid/ready handshake, and drives the RAM's word-addressed port. Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data with a one-cycle response pulse.

## Interface

Parameters:
- ADDR_W, 10, RAM word-address width; the RAM depth is 2^ADDR_W words.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [ADDR_W+1:2] select the word, [1:0] select the lane; upper bits are ignored (aliasing).
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data; the value is taken from the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors; held until the next response.
- resp_err  out  1  misaligned or illegal-size request; valid while resp_valid is high.
- ram_addr  out  ADDR_W  RAM word address.
- ram_d  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  32  RAM combinational read data.

## Operation

- **State machine:** IDLE, READ, WRITE, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid, latch we, addr, size, unsigned and wdata.
  - Decode the next state:
    - error (size 11, half with addr[0]=1, or word with addr[1:0]≠0) → RESP with err=1;
    - word store → WRITE;
    - load or sub-word store → READ.
- **READ**
  - Capture ram_q into rbuf.
  - A load → RESP. resp_rdata is loaded with the extended lane:
    - byte lane = addr[1:0], bits [8k+7:8k];
    - half lane = addr[1], bits [16k+15:16k].
  - A sub-word store → WRITE.
- **WRITE**
  - ram_we = 1.
  - ram_d depends on size:
    - word: wdata;
    - byte: rbuf with byte lane addr[1:0] replaced by wdata[7:0];
    - half: rbuf with half lane addr[1] replaced by wdata[15:0].
  - Next state → RESP.
- **RESP**
  - resp_valid = 1 for one cycle; next state → IDLE.
  - resp_err = 1 only for error requests.
  - resp_rdata = 0 for stores and errors.
- **Byte order:** little-endian lanes.
- **ram_addr:** always equals the latched word address. Nothing is written in any state except WRITE.
- **Back-to-back requests:** one transaction is outstanding at a time. req_valid seen outside IDLE is ignored and is not queued. The requester holds the request until the handshake (req_valid & req_ready).
- **Error requests:** never assert ram_we.
- **Reset**
  - Synchronous; state → IDLE.
  - All registers → 0.
  - ram_we = (state==WRITE) & ~rst, so a reset in the WRITE cycle commits no write.
  - Reset values: req_ready=1 (after the reset edge), resp_valid=0, resp_rdata=0, resp_err=0, ram_addr=0, ram_d=0, ram_we=0.

## Timing

- Cycle 0 is the handshake cycle; resp_valid goes high in the cycle shown.
  - Load: READ in cycle 1, resp_valid in cycle 2.
  - Word store: WRITE in cycle 1, resp_valid in cycle 2. The RAM updates at the end of cycle 1.
  - Sub-word store: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- req_ready returns high in the cycle after resp_valid, so the next handshake comes at the earliest one cycle after the RESP cycle.
- ram_d and ram_we are decoded from state and registers only, with no combinational path from req_* to the RAM.
- rbuf is sampled at the end of READ; ram_q must be stable by then, which holds because the RAM read is combinational from ram_addr.

## Test plan

- **Reset:** assert rst for 2 cycles during a WRITE → no RAM change; afterwards req_ready=1, resp_valid=0, ram_we=0, resp_rdata=0.
- **Word store and load:** store 0xDEADBEEF at 0x0000_0010 → ram_we for exactly one cycle with ram_addr=4 and resp_valid in cycle 2. Load word at 0x10 → resp_rdata=0xDEADBEEF, resp_err=0.
- **Byte read-modify-write:** with mem[4]=0xDEADBEEF, store byte 0x5A at 0x12 → mem[4]=0xDE5ABEEF and resp_valid in cycle 3. Load signed byte at 0x12 → 0x0000005A. Load signed byte at 0x13 → 0xFFFFFFDE; unsigned → 0x000000DE.
- **Half read-modify-write:** store half 0x8001 at 0x10 → mem[4]=0xDE5A8001. Load signed half at 0x10 → 0xFFFF8001; unsigned → 0x00008001.
- **Errors:** word load at 0x11, half store at 0x13, or size=11 → resp_valid in cycle 1, resp_err=1, resp_rdata=0, ram_we never asserted, memory unchanged.
- **Aliasing and handshake:** store a word at 0x0000_1010 → it lands in mem[4]. Hold req_valid high continuously across back-to-back requests → each is accepted only in IDLE, with one response per accepted request.
